// File: rtl/sorted_burst_serializer.sv
// sorted_burst_serializer: captures one 8-word burst on a load strobe and
// streams it out one word per valid/ready transfer. The burst sum is
// reported when the burst completes.
// Optional build macro SORT_CHECK_EN: registers an ordering check of each
// captured burst on order_err. When it is undefined, order_err is tied to 0.
module sorted_burst_serializer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SUM_W = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [8*WIDTH-1:0] din,
  output logic               busy,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic [WIDTH-1:0]   dout,
  output logic [2:0]         dout_idx,
  output logic               dout_last,
  output logic               done,
  output logic [SUM_W-1:0]   sum,
  output logic               order_err
);

  localparam int unsigned DEPTH = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t             state, state_d;
  logic [WIDTH-1:0]   words [DEPTH];
  logic [IDX_W-1:0]   ptr, ptr_d;
  logic [SUM_W-1:0]   acc, acc_d, sum_d;
  logic               capture, xfer;
  logic               busy_d, valid_d, last_d, done_d;
  logic [WIDTH-1:0]   dout_d;
  logic [IDX_W-1:0]   idx_d;

  // Next-state, datapath and next-output decode.
  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    acc_d   = acc;
    sum_d   = sum;
    capture = 1'b0;
    xfer    = dout_valid && dout_ready;
    busy_d  = 1'b0;
    valid_d = 1'b0;
    done_d  = 1'b0;
    last_d  = 1'b0;
    dout_d  = '0;
    idx_d   = '0;

    case (state)
      IDLE: begin
        if (load) begin
          capture = 1'b1;
          ptr_d   = '0;
          acc_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (xfer) begin
          acc_d = acc + SUM_W'(dout);
          if (ptr == IDX_W'(DEPTH - 1)) begin
            sum_d   = acc_d;
            state_d = DONE;
          end else begin
            ptr_d = ptr + IDX_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    valid_d = (state_d == STREAM);
    done_d = (state_d == DONE);
    if (state_d == STREAM) begin
      idx_d  = ptr_d;
      last_d = (ptr_d == IDX_W'(DEPTH - 1));
      dout_d = capture ? din[WIDTH-1:0] : words[ptr_d];
    end
  end

  // State, buffer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      acc        <= '0;
      sum        <= '0;
      busy       <= 1'b0;
      dout_valid <= 1'b0;
      dout       <= '0;
      dout_idx   <= '0;
      dout_last  <= 1'b0;
      done       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) words[i] <= '0;
    end else begin
      state      <= state_d;
      ptr        <= ptr_d;
      acc        <= acc_d;
      sum        <= sum_d;
      busy       <= busy_d;
      dout_valid <= valid_d;
      dout       <= dout_d;
      dout_idx   <= idx_d;
      dout_last  <= last_d;
      done       <= done_d;
      if (capture) begin
        for (int i = 0; i < DEPTH; i++) words[i] <= din[i*WIDTH +: WIDTH];
      end
    end
  end

`ifdef SORT_CHECK_EN
  logic order_err_d;

  // Flag any adjacent descending pair in the incoming burst.
  always_comb begin
    order_err_d = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (din[i*WIDTH +: WIDTH] > din[(i+1)*WIDTH +: WIDTH]) order_err_d = 1'b1;
    end
  end

  // Ordering result is held from one capture to the next.
  always_ff @(posedge clk) begin
    if (rst)          order_err <= 1'b0;
    else if (capture) order_err <= order_err_d;
  end
`else
  assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_sorted_burst_serializer.sv
// Bench for sorted_burst_serializer: vector table, hand-written corner
// sequences and random bursts, all checked against a transaction-level model.
module tb_sorted_burst_serializer;

  logic        clk = 1'b0;
  logic        rst, load, dout_ready;
  logic [63:0] din;
  logic        busy, dout_valid, dout_last, done, order_err;
  logic [7:0]  dout;
  logic [2:0]  dout_idx;
  logic [10:0] sum;

  int pass_cnt = 0;
  int total    = 0;
  int prev_sum = 0;

  sorted_burst_serializer #(.WIDTH(8), .SUM_W(11)) dut (
    .clk(clk), .rst(rst), .load(load), .din(din), .busy(busy),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout(dout),
    .dout_idx(dout_idx), .dout_last(dout_last), .done(done), .sum(sum),
    .order_err(order_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] din;
    int          stall_idx;
    int          stall_len;
    int          bload_idx;
    int          exp_sum;
    bit          unsorted;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic bit exp_err_of(input bit unsorted);
`ifdef SORT_CHECK_EN
    return unsorted;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int model_sum(input logic [63:0] d);
    int s = 0;
    for (int i = 0; i < 8; i++) s += int'(d[i*8 +: 8]);
    return s;
  endfunction

  function automatic bit model_unsorted(input logic [63:0] d);
    for (int i = 0; i < 7; i++)
      if (d[i*8 +: 8] > d[(i+1)*8 +: 8]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [63:0] sort_words(input logic [63:0] d);
    logic [7:0] w [8];
    logic [7:0] t;
    logic [63:0] r;
    for (int i = 0; i < 8; i++) w[i] = d[i*8 +: 8];
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 7 - i; j++)
        if (w[j] > w[j+1]) begin t = w[j]; w[j] = w[j+1]; w[j+1] = t; end
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = w[i];
    return r;
  endfunction

  // One full burst, entered and left on a negedge with the DUT idle.
  task automatic run_burst(input logic [63:0] d, input int stall_idx, input int stall_len,
                           input int bload_idx, input bit rnd, input int exp_sum, input bit exp_err);
    int k = 0;
    int stalls = 0;
    int cyc = 0;
    bit bl_done = 1'b0;
    logic [7:0] w;
    din = d; load = 1'b1; dout_ready = 1'b0;
    @(negedge clk);
    load = 1'b0;
    chk("busy_after_load", 32'(busy), 32'd1);
    chk("order_err_capture", 32'(order_err), 32'(exp_err));
    while (k < 8 && cyc < 200) begin
      w = d[k*8 +: 8];
      chk("dout_valid", 32'(dout_valid), 32'd1);
      chk("dout", 32'(dout), 32'(w));
      chk("dout_idx", 32'(dout_idx), 32'(k));
      chk("dout_last", 32'(dout_last), 32'(k == 7));
      chk("no_done_in_stream", 32'(done), 32'd0);
      chk("sum_hold", 32'(sum), 32'(prev_sum));
      if (k == stall_idx && stalls < stall_len) begin
        dout_ready = 1'b0; stalls++;
      end else if (rnd) begin
        dout_ready = ($urandom_range(0, 3) != 0);
      end else begin
        dout_ready = 1'b1;
      end
      if (k == bload_idx && !bl_done) begin
        load = 1'b1; din = '0; bl_done = 1'b1;
      end
      @(negedge clk);
      load = 1'b0;
      if (dout_ready) k++;
      cyc++;
    end
    chk("stream_timeout", 32'(cyc < 200), 32'd1);
    chk("done_pulse", 32'(done), 32'd1);
    chk("valid_low_in_done", 32'(dout_valid), 32'd0);
    chk("busy_in_done", 32'(busy), 32'd1);
    chk("sum", 32'(sum), 32'(exp_sum));
    prev_sum = exp_sum;
    // A load in the DONE cycle must be ignored.
    load = 1'b1; din = 64'h0102030405060708; dout_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    load = 1'b0; dout_ready = 1'b1;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_after_done", 32'(busy), 32'd0);
    chk("no_valid_idle", 32'(dout_valid), 32'd0);
    chk("sum_after_done", 32'(sum), 32'(exp_sum));
    chk("order_err_hold", 32'(order_err), 32'(exp_err));
  endtask

  localparam logic [63:0] NOM   = {8'hFF, 8'hC3, 8'h80, 8'h48, 8'h37, 8'h22, 8'h10, 8'h05};
  localparam logic [63:0] UNSRT = {8'hFF, 8'hC3, 8'h80, 8'h48, 8'h01, 8'h22, 8'h10, 8'h05};

  initial begin
    logic [63:0] rd;
    int waited;
    bit saw_done;

    vecs[0] = '{NOM,   -1, 0, -1,  760, 1'b0};
    vecs[1] = '{NOM,    2, 3, -1,  760, 1'b0};
    vecs[2] = '{{8{8'hFF}}, -1, 0, -1, 2040, 1'b0};
    vecs[3] = '{NOM,   -1, 0,  3,  760, 1'b0};
    vecs[4] = '{UNSRT, -1, 0, -1,  706, 1'b1};
    vecs[5] = '{NOM,   -1, 0, -1,  760, 1'b0};

    rst = 1'b1; load = 1'b0; dout_ready = 1'b0; din = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_idx", 32'(dout_idx), 32'd0);
    chk("rst_last", 32'(dout_last), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_order_err", 32'(order_err), 32'd0);

    // Ready without valid must not start anything.
    dout_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("ready_while_idle", 32'(busy), 32'd0);

    for (int i = 0; i < 6; i++)
      run_burst(vecs[i].din, vecs[i].stall_idx, vecs[i].stall_len, vecs[i].bload_idx,
                1'b0, vecs[i].exp_sum, exp_err_of(vecs[i].unsorted));

    // Reset mid-stream aborts the burst with no done pulse.
    din = UNSRT; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("mid_rst_order_err", 32'(order_err), 32'(exp_err_of(1'b1)));
    waited = 0;
    while (dout_idx != 3'd4 && waited < 20) begin
      @(negedge clk); waited++;
    end
    chk("mid_rst_reach_idx4", 32'(dout_idx), 32'd4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_valid", 32'(dout_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_sum", 32'(sum), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_dout", 32'(dout), 32'd0);
    chk("mid_rst_idx", 32'(dout_idx), 32'd0);
    chk("mid_rst_order_clr", 32'(order_err), 32'd0);
    prev_sum = 0;
    saw_done = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("mid_rst_no_done", 32'(saw_done), 32'd0);

    // rst and load together: rst wins.
    rst = 1'b1; load = 1'b1; din = NOM;
    @(negedge clk);
    rst = 1'b0; load = 1'b0;
    chk("rst_load_busy", 32'(busy), 32'd0);
    chk("rst_load_valid", 32'(dout_valid), 32'd0);

    // Random bursts with random backpressure against the model.
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < 8; i++) rd[i*8 +: 8] = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) rd = sort_words(rd);
      run_burst(rd, -1, 0, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1,
                1'b1, model_sum(rd), exp_err_of(model_unsorted(rd)));
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
